mc_control_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It replaces the single-cycle opcode decoder with a state machine that walks each instruction through fetch, decode, execute, memory and writeback. The shared ALU and unified memory are reused across cycles. It drives enable and mux-select signals into the multi-cycle datapath: PC, IR, the A/B/MDR/ALUOut latches, the register file, the ALU and memory. It also owns halt detection.

---
 rtl/mc_control_fsm.sv | 175 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath enables and mux selects.
module mc_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_req,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       is_halted,
    output logic [3:0] state
);

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcI      = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    typedef enum logic [3:0] {
        StIf     = 4'd0,
        StId     = 4'd1,
        StExR    = 4'd2,
        StExI    = 4'd3,
        StExAddr = 4'd4,
        StMemLd  = 4'd5,
        StMemSt  = 4'd6,
        StWbAlu  = 4'd7,
        StWbLd   = 4'd8,
        StBr     = 4'd9,
        StBrNt   = 4'd10,
        StJal    = 4'd11,
        StJalrEx = 4'd12,
        StJalrWb = 4'd13,
        StSys    = 4'd14,
        StHalt   = 4'd15
    } state_e;

    state_e state_q, state_d;
    logic   halt_now;
    logic   pc_plus4;

    assign halt_now = (opcode == OpcSystem) && halt_req;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIf: state_d = StId;
            StId: begin
                case (opcode)
                    OpcR:               state_d = StExR;
                    OpcI:               state_d = StExI;
                    OpcLoad, OpcStore:  state_d = StExAddr;
                    OpcBranch:          state_d = StBr;
                    OpcJal:             state_d = StJal;
                    OpcJalr:            state_d = StJalrEx;
                    default:            state_d = StSys;
                endcase
            end
            StExR, StExI: state_d = StWbAlu;
            StExAddr:     state_d = (opcode == OpcLoad) ? StMemLd : StMemSt;
            StMemLd:      state_d = StWbLd;
            StMemSt, StWbAlu, StWbLd, StBrNt, StJal, StJalrWb: state_d = StIf;
            StBr:         state_d = bcond ? StIf : StBrNt;
            StJalrEx:     state_d = StJalrWb;
            StSys:        state_d = halt_now ? StHalt : StIf;
            StHalt:       state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Reset gates every output so an aborted instruction can never write anything.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        pc_source  = 2'd0;
        is_halted  = 1'b0;
        pc_plus4   = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StIf: begin
                    mem_read = 1'b1;
                    ir_write = 1'b1;
                end
                StId: alu_src_b = 2'd2;
                StExR: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd2;
                end
                StExI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu_op    = 2'd2;
                end
                StExAddr, StJalrEx: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                StMemLd: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                StMemSt: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                    pc_plus4  = 1'b1;
                end
                StWbAlu: begin
                    reg_write = 1'b1;
                    pc_plus4  = 1'b1;
                end
                StWbLd: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                    pc_plus4   = 1'b1;
                end
                StBr: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd1;
                    pc_source = 2'd1;
                    pc_write  = bcond;
                end
                StBrNt: pc_plus4 = 1'b1;
                StJal, StJalrWb: begin
                    // ALU forms the link address PC+4 while PC loads the latched target.
                    alu_src_b  = 2'd1;
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd2;
                    pc_write   = 1'b1;
                    pc_source  = (state_q == StJal) ? 2'd1 : 2'd2;
                end
                StSys:  pc_plus4 = !halt_now;
                StHalt: is_halted = 1'b1;
            endcase
            if (pc_plus4) begin
                alu_src_a = 1'b0;
                alu_src_b = 2'd1;
                alu_op    = 2'd0;
                pc_source = 2'd0;
                pc_write  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: driver pushes expected per-cycle controls derived
// from instruction-level rules; a negedge monitor pops and compares.
module tb_mc_control_fsm;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcI      = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcEcall  = 7'b1110011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = OpcR;
    logic       bcond = 1'b0;
    logic       halt_req = 1'b0;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a, is_halted;
    logic [1:0] mem_to_reg, alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    mc_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .bcond      (bcond),
        .halt_req   (halt_req),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .is_halted  (is_halted),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic        chk;
        logic [15:0] ctrl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;
    logic final_req = 1'b0;
    logic final_done = 1'b0;

    // Expected controls for one cycle spent in a given step of an instruction.
    function automatic logic [15:0] ctrl_of(input int st, input logic bc, input logic [6:0] op,
                                            input logic hr);
        logic       pcw, irw, iod, mr, mw, rw, asa, hal, pc4;
        logic [1:0] m2r, asb, aop, psrc;
        {pcw, irw, iod, mr, mw, rw, asa, hal, pc4} = '0;
        {m2r, asb, aop, psrc} = '0;
        case (st)
            0:  begin mr = 1; irw = 1; end
            1:  asb = 2;
            2:  begin asa = 1; aop = 2; end
            3:  begin asa = 1; asb = 2; aop = 2; end
            4:  begin asa = 1; asb = 2; end
            5:  begin iod = 1; mr = 1; end
            6:  begin iod = 1; mw = 1; pc4 = 1; end
            7:  begin rw = 1; pc4 = 1; end
            8:  begin rw = 1; m2r = 1; pc4 = 1; end
            9:  begin asa = 1; aop = 1; psrc = 1; pcw = bc; end
            10: pc4 = 1;
            11: begin asb = 1; rw = 1; m2r = 2; pcw = 1; psrc = 1; end
            12: begin asa = 1; asb = 2; end
            13: begin asb = 1; rw = 1; m2r = 2; pcw = 1; psrc = 2; end
            14: pc4 = !(op == OpcEcall && hr);
            default: hal = 1;
        endcase
        if (pc4) begin
            asb = 1;
            pcw = 1;
        end
        return {pcw, irw, iod, mr, mw, rw, m2r, asa, asb, aop, psrc, hal};
    endfunction

    // i-th state visited by an instruction; -1 once it has retired.
    function automatic int path_of(input logic [6:0] op, input logic bc, input logic hr,
                                   input int i);
        int p[$];
        p = {0, 1};
        if (op == OpcR) p = {p, 2, 7};
        else if (op == OpcI) p = {p, 3, 7};
        else if (op == OpcLoad) p = {p, 4, 5, 8};
        else if (op == OpcStore) p = {p, 4, 6};
        else if (op == OpcBranch) p = bc ? {p, 9} : {p, 9, 10};
        else if (op == OpcJal) p = {p, 11};
        else if (op == OpcJalr) p = {p, 12, 13};
        else if (op == OpcEcall && hr) p = {p, 14, 15};
        else p = {p, 14};
        return (i < p.size()) ? p[i] : -1;
    endfunction

    task automatic push_exp(input int st, input logic chk, input logic [15:0] ctrl);
        exp_t e;
        e.st = 4'(st);
        e.chk = chk;
        e.ctrl = ctrl;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) push_exp(0, 1'b0, 16'h0);
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic bc, input logic hr,
                             input int limit, output logic halted);
        int n = 0;
        int st;
        opcode = op;
        bcond = bc;
        halt_req = hr;
        halted = 1'b0;
        st = path_of(op, bc, hr, 0);
        while (st >= 0 && n < limit) begin
            push_exp(st, 1'b1, ctrl_of(st, bc, op, hr));
            if (st == 15) halted = 1'b1;
            n++;
            st = path_of(op, bc, hr, n);
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic halt_idle(input int n);
        for (int i = 0; i < n; i++) begin
            opcode = 7'($urandom);
            bcond = 1'($urandom);
            halt_req = 1'($urandom);
            push_exp(15, 1'b1, ctrl_of(15, 1'b0, 7'h0, 1'b0));
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [6:0] rand_unknown();
        logic [6:0] op;
        do op = 7'($urandom);
        while (op == OpcR || op == OpcI || op == OpcLoad || op == OpcStore || op == OpcBranch
               || op == OpcJal || op == OpcJalr || op == OpcEcall);
        return op;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL underflow: DUT cycle with no expected entry, state=%0d", state);
            end else begin
                e = exp_q.pop_front();
                if ({pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
                     alu_src_a, alu_src_b, alu_op, pc_source, is_halted} !== e.ctrl) begin
                    failures++;
                    $display("FAIL ctrl t=%0t st=%0d got=%h exp=%h", $time, state,
                             {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                              mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, is_halted},
                             e.ctrl);
                end
                if (e.chk) begin
                    checks++;
                    if (state !== e.st) begin
                        failures++;
                        $display("FAIL state t=%0t got=%0d exp=%0d", $time, state, e.st);
                    end
                end
            end
        end
        if (final_req && !final_done) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL drain: %0d expected entries left, need 0", exp_q.size());
            end
            final_done <= 1'b1;
        end
    end

    initial begin
        logic        h;
        logic [6:0]  op;
        logic        bc, hr;
        int          k, len;
        logic [6:0]  ops [8] = '{OpcR, OpcI, OpcLoad, OpcStore, OpcBranch, OpcJal, OpcJalr,
                                 OpcEcall};
        @(posedge clk);
        #1 mon_en = 1'b1;
        opcode = OpcR;
        do_reset(3);

        run_instr(OpcR, 1'b0, 1'b0, 99, h);
        run_instr(OpcI, 1'b1, 1'b0, 99, h);
        run_instr(OpcLoad, 1'b0, 1'b0, 99, h);
        run_instr(OpcStore, 1'b0, 1'b0, 99, h);
        run_instr(OpcBranch, 1'b1, 1'b0, 99, h);
        run_instr(OpcBranch, 1'b0, 1'b0, 99, h);
        run_instr(OpcJal, 1'b0, 1'b0, 99, h);
        run_instr(OpcJalr, 1'b0, 1'b0, 99, h);
        run_instr(OpcEcall, 1'b0, 1'b0, 99, h);
        run_instr(rand_unknown(), 1'b1, 1'b1, 99, h);
        run_instr(OpcLoad, 1'b0, 1'b0, 4, h);
        do_reset(1);
        run_instr(OpcEcall, 1'b0, 1'b1, 99, h);
        halt_idle(10);
        do_reset(2);

        for (int n = 0; n < 120; n++) begin
            k = $urandom_range(0, 9);
            op = (k >= 8) ? rand_unknown() : ops[k];
            bc = 1'($urandom);
            hr = ($urandom_range(0, 3) == 0);
            len = 0;
            while (path_of(op, bc, hr, len) >= 0) len++;
            if ($urandom_range(0, 9) == 0) begin
                run_instr(op, bc, hr, $urandom_range(1, len), h);
                if (!h) do_reset($urandom_range(1, 2));
            end else begin
                run_instr(op, bc, hr, 99, h);
            end
            if (h) begin
                halt_idle($urandom_range(1, 5));
                do_reset($urandom_range(1, 2));
            end
        end

        mon_en = 1'b0;
        final_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (!final_done) begin
            failures++;
            $display("FAIL drain: monitor never ran, need done=1");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
